start_sequencer: RTL

- Upstream control stage for the SNES clock generator. It produces that generator's active-low run/reset input and its active-low APU-sync input.
- It synchronises and debounces the console reset button, waits for PLL lock, and enforces a minimum reset hold time.
- It then arms on the first real APU sync falling edge and releases the console.
- It reports sequencing state for the LED matrix.

---
 rtl/tastable_pkg.sv | 19 +
 rtl/start_sequencer_sync_debounce.sv | 51 +++++
 rtl/start_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tastable_pkg.sv
// Shared state encoding and default timing for the SNES clock-generator start sequencer.
package tastable_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_HOLD      = 3'd1,
    ST_ARM       = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  localparam int DEF_SYNC_STAGES      = 2;
  localparam int DEF_DEBOUNCE_CYCLES  = 65536;
  localparam int DEF_MIN_RESET_CYCLES = 1024;
  localparam int DEF_SYNC_TIMEOUT     = 16777216;
  localparam int DEF_SYNC_PULSE       = 16;
  localparam int DEF_CNT_W            = 24;

endpackage

// File: rtl/start_sequencer_sync_debounce.sv
// N-stage input synchroniser with an optional level debouncer (CYCLES=0 bypasses the debouncer).
module sync_debounce #(
  parameter int   STAGES    = 2,
  parameter int   CYCLES    = 0,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [STAGES-1:0] sync_r;

  // Shift the asynchronous input through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {STAGES{RESET_VAL}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], din};
    end
  end

  if (CYCLES == 0) begin : g_sync_only
    assign dout = sync_r[STAGES-1];
  end else begin : g_debounce
    localparam int DW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    logic [DW-1:0] cnt_r;
    logic          deb_r;

    // Accept a new level only after it has differed for CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r <= '0;
        deb_r <= RESET_VAL;
      end else if (sync_r[STAGES-1] != deb_r) begin
        if (cnt_r == DW'(CYCLES - 1)) begin
          deb_r <= sync_r[STAGES-1];
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_r + DW'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end

    assign dout = deb_r;
  end

endmodule

// File: rtl/start_sequencer.sv
// Start sequencer: waits for PLL lock, holds reset, arms on the first APU sync edge and releases the console.
import tastable_pkg::*;

module start_sequencer #(
  parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int MIN_RESET_CYCLES = DEF_MIN_RESET_CYCLES,
  parameter int SYNC_TIMEOUT     = DEF_SYNC_TIMEOUT,
  parameter int SYNC_PULSE       = DEF_SYNC_PULSE,
  parameter int CNT_W            = DEF_CNT_W
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       btn_reset_n,
  input  logic       apusync_raw,
  output logic       run_n,
  output logic       apusync_out,
  output logic       running,
  output logic       fault,
  output logic [2:0] state
);

  logic             lock_s;
  logic             btn_deb_s;
  logic             apu_s;
  logic             fall_det_s;
  logic             apu_prev_r;
  logic             btn_prev_r;
  logic             btn_press_r;
  state_t           state_r;
  state_t           state_n;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_n;
  logic             apu_out_n;
  logic             run_n_r;
  logic             apu_out_r;
  logic             running_r;
  logic             fault_r;

  // Lock synchroniser clears so lock is never assumed before it has been seen.
  sync_debounce #(.STAGES(SYNC_STAGES), .CYCLES(0), .RESET_VAL(1'b0)) u_lock (
    .clk(clkin), .rst_n(reset), .din(pll_lock), .dout(lock_s)
  );

  sync_debounce #(.STAGES(SYNC_STAGES), .CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(1'b1)) u_button (
    .clk(clkin), .rst_n(reset), .din(btn_reset_n), .dout(btn_deb_s)
  );

  sync_debounce #(.STAGES(SYNC_STAGES), .CYCLES(0), .RESET_VAL(1'b1)) u_apusync (
    .clk(clkin), .rst_n(reset), .din(apusync_raw), .dout(apu_s)
  );

  assign fall_det_s = apu_prev_r & ~apu_s;

  // Edge history for APU sync and a registered press pulse from the debounced button.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      apu_prev_r  <= 1'b1;
      btn_prev_r  <= 1'b1;
      btn_press_r <= 1'b0;
    end else begin
      apu_prev_r  <= apu_s;
      btn_prev_r  <= btn_deb_s;
      btn_press_r <= btn_prev_r & ~btn_deb_s;
    end
  end

  // Next-state, counter and pulse logic; lock loss then button press override normal flow.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    apu_out_n = 1'b1;
    if (!lock_s && (state_r != ST_WAIT_LOCK)) begin
      state_n = ST_WAIT_LOCK;
      cnt_n   = '0;
    end else if (btn_press_r && ((state_r == ST_ARM) || (state_r == ST_RUN) || (state_r == ST_FAULT))) begin
      state_n = ST_HOLD;
      cnt_n   = '0;
    end else begin
      case (state_r)
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_n = ST_HOLD;
            cnt_n   = '0;
          end else begin
            cnt_n = '0;
          end
        end
        ST_HOLD: begin
          if (cnt_r == CNT_W'(MIN_RESET_CYCLES - 1)) begin
            if (btn_deb_s) begin
              state_n = ST_ARM;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_r;
            end
          end else begin
            cnt_n = cnt_r + CNT_W'(1);
          end
        end
        ST_ARM: begin
          if (fall_det_s) begin
            state_n   = ST_RUN;
            cnt_n     = CNT_W'(SYNC_PULSE - 1);
            apu_out_n = 1'b0;
          end else if (cnt_r == CNT_W'(SYNC_TIMEOUT - 1)) begin
            state_n = ST_FAULT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_r + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (cnt_r != '0) begin
            cnt_n     = cnt_r - CNT_W'(1);
            apu_out_n = 1'b0;
          end else begin
            apu_out_n = 1'b1;
          end
        end
        ST_FAULT: begin
          cnt_n = '0;
        end
        default: begin
          state_n = ST_WAIT_LOCK;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_WAIT_LOCK;
      cnt_r     <= '0;
      run_n_r   <= 1'b0;
      apu_out_r <= 1'b1;
      running_r <= 1'b0;
      fault_r   <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      run_n_r   <= (state_n == ST_RUN);
      apu_out_r <= apu_out_n;
      running_r <= (state_n == ST_RUN);
      fault_r   <= (state_n == ST_FAULT);
    end
  end

  assign run_n       = run_n_r;
  assign apusync_out = apu_out_r;
  assign running     = running_r;
  assign fault       = fault_r;
  assign state       = state_r;

endmodule
